// File: rtl/id_hazard_ctrl_if.sv
// Decode-to-hazard-control bundle: decoded operands in, issue/flush/forward controls out.
// Latency: none; plain wires grouped for port tidiness.
// Backpressure: id_ready_go low holds the decode instruction in place.
interface id_hazard_ctrl_if;
    logic        id_valid;
    logic [4:0]  id_rj;
    logic        id_rj_used;
    logic [4:0]  id_rkd;
    logic        id_rkd_used;
    logic [4:0]  id_dest;
    logic        id_rf_we;
    logic        id_is_load;
    logic        id_br_taken;
    logic        id_ready_go;
    logic        ex_valid_in;
    logic        if_flush;
    logic [1:0]  fwd_sel_rj;
    logic [1:0]  fwd_sel_rkd;
    logic [31:0] stall_cnt;

    modport master (
        output id_valid, id_rj, id_rj_used, id_rkd, id_rkd_used,
               id_dest, id_rf_we, id_is_load, id_br_taken,
        input  id_ready_go, ex_valid_in, if_flush, fwd_sel_rj, fwd_sel_rkd, stall_cnt
    );

    modport slave (
        input  id_valid, id_rj, id_rj_used, id_rkd, id_rkd_used,
               id_dest, id_rf_we, id_is_load, id_br_taken,
        output id_ready_go, ex_valid_in, if_flush, fwd_sel_rj, fwd_sel_rkd, stall_cnt
    );
endinterface

// File: rtl/id_hazard_ctrl.sv
// Decode-stage RAW hazard detection, operand forwarding select and branch flush (BYPASS_EN enables forwarding).
// Latency: combinational issue decision; hazard-free instructions issue in the cycle they are valid.
// Backpressure: a hazard drops id_ready_go and injects an execute bubble until the producer clears.
module id_hazard_ctrl #(
    // Reset value of the stall counter.
    parameter logic [31:0] CNT_INIT = 32'd0
) (
    input  logic           clk,
    input  logic           reset,
    id_hazard_ctrl_if.slave hz
);

    typedef struct packed {
        logic       valid;
        logic       we;
        logic [4:0] dest;
        logic       is_load;
    } trk_t;

    trk_t        ex_q;
    trk_t        mem_q;
    trk_t        wb_q;
    logic [31:0] cnt_q;

    logic rj_ex, rj_mem, rj_wb;
    logic rkd_ex, rkd_mem, rkd_wb;
    logic hazard;
    logic ready_go;
    logic issue;
    logic [1:0] sel_rj;
    logic [1:0] sel_rkd;

    // r0 is hardwired to zero, so it never matches a producer.
    function automatic logic src_hit(input trk_t e, input logic used, input logic [4:0] src);
        return used && (src != 5'd0) && e.valid && e.we && (e.dest == src);
    endfunction

`ifdef BYPASS_EN
    // Youngest producer wins: EX holds the most recent result.
    function automatic logic [1:0] pick(input logic at_ex, input logic at_mem, input logic at_wb);
        if (at_ex)       return 2'd1;
        else if (at_mem) return 2'd2;
        else if (at_wb)  return 2'd3;
        else             return 2'd0;
    endfunction
`endif

    // Match both sources against every tracked stage, then decide issue and forwarding.
    always_comb begin
        rj_ex   = src_hit(ex_q,  hz.id_rj_used,  hz.id_rj);
        rj_mem  = src_hit(mem_q, hz.id_rj_used,  hz.id_rj);
        rj_wb   = src_hit(wb_q,  hz.id_rj_used,  hz.id_rj);
        rkd_ex  = src_hit(ex_q,  hz.id_rkd_used, hz.id_rkd);
        rkd_mem = src_hit(mem_q, hz.id_rkd_used, hz.id_rkd);
        rkd_wb  = src_hit(wb_q,  hz.id_rkd_used, hz.id_rkd);
        hazard  = 1'b0;
        sel_rj  = 2'd0;
        sel_rkd = 2'd0;
`ifdef BYPASS_EN
        // Only a load still in EX cannot be forwarded yet.
        hazard = ex_q.is_load & (rj_ex | rkd_ex);
        if (hz.id_valid) begin
            sel_rj  = pick(rj_ex,  rj_mem,  rj_wb);
            sel_rkd = pick(rkd_ex, rkd_mem, rkd_wb);
        end
`else
        // Regfile write lands at the WB edge, so any in-flight producer blocks.
        hazard = rj_ex | rj_mem | rj_wb | rkd_ex | rkd_mem | rkd_wb;
`endif
        ready_go = ~hz.id_valid | ~hazard;
        issue    = hz.id_valid & ready_go;
    end

    assign hz.id_ready_go = ready_go;
    assign hz.ex_valid_in = issue;
    assign hz.if_flush    = issue & hz.id_br_taken;
    assign hz.fwd_sel_rj  = sel_rj;
    assign hz.fwd_sel_rkd = sel_rkd;
    assign hz.stall_cnt   = cnt_q;

    // Load/use flags of older stages only matter with forwarding enabled.
    logic unused_bits;
    assign unused_bits = ^{mem_q.is_load, wb_q.is_load, ex_q.is_load};

    // Shift the producer tracker every cycle; a stall enters EX as a bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= '{valid: issue, we: hz.id_rf_we, dest: hz.id_dest, is_load: hz.id_is_load};
            mem_q <= ex_q;
            wb_q  <= mem_q;
        end
    end

    // Saturating count of cycles a valid decode instruction was held back.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= CNT_INIT;
        end else if (hz.id_valid && !ready_go && (cnt_q != 32'hFFFF_FFFF)) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

endmodule
